// File: rtl/pixel_array_ctrl.sv
`timescale 1ns/1ps
// pixel_array_ctrl
// Sequences one image frame through a pixel array: erase, expose, single-slope
// ADC conversion (broadcast 8-bit ramp code), then row-by-row readout streamed
// out one pixel per accepted valid/ready handshake.
//
// Ports
//   CLK, RESET_N             clock, asynchronous active-low reset
//   START                    frame request (only honoured in IDLE)
//   ABORT                    synchronous abort of a running frame
//   ERASE, EXPOSE, RAMP      array phase drives
//   COUNTER[7:0]             ADC code broadcast during conversion
//   READ[H-1:0]              one-hot row select
//   DATA_IN[W*8-1:0]         column data from array, column c at [c*8 +: 8]
//   OUT_DATA/VALID/READY     pixel stream handshake, OUT_LAST on final pixel
//   BUSY                     high whenever not IDLE
//   FRAME_DONE               one-cycle pulse after the last pixel is accepted
module pixel_array_ctrl #(
  parameter int unsigned PIXEL_ARRAY_HEIGHT = 2,
  parameter int unsigned PIXEL_ARRAY_WIDTH  = 2,
  parameter int unsigned ERASE_CYCLES       = 4,
  parameter int unsigned EXPOSE_CYCLES      = 8
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  input  logic                             START,
  input  logic                             ABORT,
  output logic                             ERASE,
  output logic                             EXPOSE,
  output logic                             RAMP,
  output logic [7:0]                       COUNTER,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]    READ,
  input  logic [PIXEL_ARRAY_WIDTH*8-1:0]   DATA_IN,
  output logic [7:0]                       OUT_DATA,
  output logic                             OUT_VALID,
  input  logic                             OUT_READY,
  output logic                             OUT_LAST,
  output logic                             BUSY,
  output logic                             FRAME_DONE
);

  localparam int unsigned H         = PIXEL_ARRAY_HEIGHT;
  localparam int unsigned W         = PIXEL_ARRAY_WIDTH;
  localparam int unsigned ROW_W     = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned COL_W     = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned PH_MAX    = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int unsigned CNT_MAX   = (PH_MAX > 256) ? PH_MAX : 256;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX);
  localparam int unsigned READ_CYC  = 2;

  typedef enum logic [2:0] {
    IDLE,
    ERASE_S,
    EXPOSE_S,
    CONVERT,
    READ_ROW,
    STREAM
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [7:0]         col_buf_q [W];
  logic [7:0]         col_buf_d [W];

  logic               erase_d, expose_d, ramp_d, out_valid_d, out_last_d, busy_d, frame_done_d;
  logic [7:0]         counter_d, out_data_d;
  logic [H-1:0]       read_d;

  // Next-state, counters, and the registered output values for the next cycle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    col_d        = col_q;
    col_buf_d    = col_buf_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = ERASE_S;
          cnt_d   = '0;
        end
      end
      ERASE_S: begin
        if (cnt_q == CNT_W'(ERASE_CYCLES - 1)) begin
          state_d = EXPOSE_S;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EXPOSE_S: begin
        if (cnt_q == CNT_W'(EXPOSE_CYCLES - 1)) begin
          state_d = CONVERT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CONVERT: begin
        if (cnt_q == CNT_W'(255)) begin
          state_d = READ_ROW;
          cnt_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ_ROW: begin
        // Array output settles during the first select cycle; sample at the end of the second
        if (cnt_q == CNT_W'(READ_CYC - 1)) begin
          for (int c = 0; c < int'(W); c++) begin
            col_buf_d[c] = DATA_IN[c*8 +: 8];
          end
          state_d = STREAM;
          cnt_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STREAM: begin
        if (OUT_READY) begin
          if (col_q == COL_W'(W - 1)) begin
            if (row_q == ROW_W'(H - 1)) begin
              state_d      = IDLE;
              frame_done_d = 1'b1;
            end else begin
              state_d = READ_ROW;
              row_d   = row_q + ROW_W'(1);
              cnt_d   = '0;
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything, including a completing handshake
    if (ABORT && (state_q != IDLE)) begin
      state_d      = IDLE;
      cnt_d        = '0;
      row_d        = '0;
      col_d        = '0;
      frame_done_d = 1'b0;
    end

    erase_d     = (state_d == ERASE_S);
    expose_d    = (state_d == EXPOSE_S);
    ramp_d      = (state_d == CONVERT);
    counter_d   = (state_d == CONVERT) ? 8'(cnt_d) : 8'd0;
    read_d      = (state_d == READ_ROW) ? (H'(1) << row_d) : '0;
    out_valid_d = (state_d == STREAM);
    out_data_d  = (state_d == STREAM) ? col_buf_d[col_d] : 8'd0;
    out_last_d  = (state_d == STREAM) && (row_d == ROW_W'(H - 1)) && (col_d == COL_W'(W - 1));
    busy_d      = (state_d != IDLE);
  end

  // State, counters, column buffer and all outputs
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      for (int c = 0; c < int'(W); c++) begin
        col_buf_q[c] <= 8'd0;
      end
      ERASE      <= 1'b0;
      EXPOSE     <= 1'b0;
      RAMP       <= 1'b0;
      COUNTER    <= 8'd0;
      READ       <= '0;
      OUT_DATA   <= 8'd0;
      OUT_VALID  <= 1'b0;
      OUT_LAST   <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      col_buf_q  <= col_buf_d;
      ERASE      <= erase_d;
      EXPOSE     <= expose_d;
      RAMP       <= ramp_d;
      COUNTER    <= counter_d;
      READ       <= read_d;
      OUT_DATA   <= out_data_d;
      OUT_VALID  <= out_valid_d;
      OUT_LAST   <= out_last_d;
      BUSY       <= busy_d;
      FRAME_DONE <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
`timescale 1ns/1ps
// Directed bench for pixel_array_ctrl at default parameters (2x2 array).
module tb_pixel_array_ctrl;

  logic        CLK;
  logic        RESET_N;
  logic        START;
  logic        ABORT;
  logic        ERASE;
  logic        EXPOSE;
  logic        RAMP;
  logic [7:0]  COUNTER;
  logic [1:0]  READ;
  logic [15:0] DATA_IN;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        OUT_LAST;
  logic        BUSY;
  logic        FRAME_DONE;

  int checks = 0;
  int errors = 0;

  logic [7:0] pix_q [$];
  bit         last_q [$];
  logic [7:0] stall_q [$];
  bit         stall_last_seen;
  logic [7:0] exp_pix [4] = '{8'h12, 8'h34, 8'hAB, 8'hCD};

  // All outputs packed for whole-vector comparisons
  logic [24:0] obs;
  assign obs = {ERASE, EXPOSE, RAMP, COUNTER, READ, OUT_VALID, OUT_DATA, OUT_LAST, BUSY, FRAME_DONE};

  // Array model: selected row drives its column values, col0 in the low byte
  always_comb begin
    case (READ)
      2'b01:   DATA_IN = {8'h34, 8'h12};
      2'b10:   DATA_IN = {8'hCD, 8'hAB};
      default: DATA_IN = 16'h0000;
    endcase
  end

  pixel_array_ctrl dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .ABORT      (ABORT),
    .ERASE      (ERASE),
    .EXPOSE     (EXPOSE),
    .RAMP       (RAMP),
    .COUNTER    (COUNTER),
    .READ       (READ),
    .DATA_IN    (DATA_IN),
    .OUT_DATA   (OUT_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_LAST   (OUT_LAST),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Pulses START in the current cycle and runs one frame, collecting accepted pixels.
  // stall: OUT_READY held low for that many cycles on the first presented pixel.
  // poke: additionally pulse START once in EXPOSE_S and once in STREAM.
  task automatic run_frame(input int stall, input bit poke, output int n_done, output int done_cyc);
    int  stall_left;
    bit  poked_e;
    bit  poked_s;
    pix_q.delete();
    last_q.delete();
    stall_q.delete();
    stall_last_seen = 1'b0;
    n_done     = 0;
    done_cyc   = 0;
    stall_left = stall;
    poked_e    = 1'b0;
    poked_s    = 1'b0;
    OUT_READY  = 1'b1;
    START      = 1'b1;
    for (int c = 1; c <= 700; c++) begin
      tick();
      START = 1'b0;
      if (FRAME_DONE) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (poke && EXPOSE && !poked_e) begin
        START   = 1'b1;
        poked_e = 1'b1;
      end
      if (poke && OUT_VALID && !poked_s) begin
        START   = 1'b1;
        poked_s = 1'b1;
      end
      if (OUT_VALID && stall_left > 0) begin
        OUT_READY = 1'b0;
        stall_left--;
        stall_q.push_back(OUT_DATA);
        if (OUT_LAST) stall_last_seen = 1'b1;
      end else begin
        OUT_READY = 1'b1;
      end
      if (OUT_VALID && OUT_READY) begin
        pix_q.push_back(OUT_DATA);
        last_q.push_back(OUT_LAST);
      end
      if (done_cyc > 0 && c >= done_cyc + 3) break;
    end
    START     = 1'b0;
    OUT_READY = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, 25'd0);
    end
  endtask

  task automatic test_frame_timing();
    logic [24:0] exp;
    logic [7:0]  cnt_e, data_e;
    logic [1:0]  read_e;
    START = 1'b1;
    for (int c = 1; c <= 280; c++) begin
      tick();
      START  = 1'b0;
      cnt_e  = (c >= 13 && c <= 268) ? 8'(c - 13) : 8'd0;
      read_e = (c == 269 || c == 270) ? 2'b01 : (c == 273 || c == 274) ? 2'b10 : 2'b00;
      case (c)
        271:     data_e = 8'h12;
        272:     data_e = 8'h34;
        275:     data_e = 8'hAB;
        276:     data_e = 8'hCD;
        default: data_e = 8'h00;
      endcase
      exp = {(c >= 1 && c <= 4), (c >= 5 && c <= 12), (c >= 13 && c <= 268), cnt_e, read_e,
             (c == 271 || c == 272 || c == 275 || c == 276), data_e, (c == 276),
             (c >= 1 && c <= 276), (c == 277)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL frame_timing cycle %0d: got %h expected %h", c, obs, exp);
      end
    end
  endtask

  task automatic test_pixel_order();
    int n_done, done_cyc;
    run_frame(0, 1'b0, n_done, done_cyc);
    checks++;
    if (n_done !== 1 || done_cyc !== 277) begin
      errors++;
      $display("FAIL order_done: got count %0d cycle %0d expected count 1 cycle 277", n_done, done_cyc);
    end
    checks++;
    if (pix_q.size() !== 4) begin
      errors++;
      $display("FAIL order_count: got %0d pixels expected 4", pix_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pix_q[i] !== exp_pix[i] || last_q[i] !== (i == 3)) begin
          errors++;
          $display("FAIL order_pixel %0d: got %h last %0d expected %h last %0d",
                   i, pix_q[i], last_q[i], exp_pix[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int n_done, done_cyc;
    run_frame(3, 1'b0, n_done, done_cyc);
    checks++;
    if (stall_q.size() !== 3 || stall_last_seen) begin
      errors++;
      $display("FAIL bp_stall: got %0d stall cycles last %0d expected 3 last 0", stall_q.size(), stall_last_seen);
    end
    foreach (stall_q[i]) begin
      checks++;
      if (stall_q[i] !== 8'h12) begin
        errors++;
        $display("FAIL bp_hold %0d: got %h expected 12", i, stall_q[i]);
      end
    end
    checks++;
    if (pix_q.size() !== 4) begin
      errors++;
      $display("FAIL bp_count: got %0d pixels expected 4", pix_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pix_q[i] !== exp_pix[i]) begin
          errors++;
          $display("FAIL bp_pixel %0d: got %h expected %h", i, pix_q[i], exp_pix[i]);
        end
      end
    end
    checks++;
    if (n_done !== 1 || done_cyc !== 280) begin
      errors++;
      $display("FAIL bp_done: got count %0d cycle %0d expected count 1 cycle 280", n_done, done_cyc);
    end
  endtask

  task automatic test_start_ignored();
    int n_done, done_cyc;
    run_frame(0, 1'b1, n_done, done_cyc);
    checks++;
    if (n_done !== 1 || done_cyc !== 277 || pix_q.size() !== 4) begin
      errors++;
      $display("FAIL start_ignored: got done %0d cycle %0d pixels %0d expected 1 277 4",
               n_done, done_cyc, pix_q.size());
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL start_ignored_idle: got busy %0d expected 0", BUSY);
    end
  endtask

  task automatic test_abort();
    int  n_done, done_cyc;
    bit  found;
    // Abort in IDLE does nothing
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL abort_idle: got %h expected %h", obs, 25'd0);
    end
    // Abort mid-conversion
    START = 1'b1;
    found = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      tick();
      START = 1'b0;
      if (RAMP && COUNTER == 8'd100) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_reach: got no COUNTER=100 expected COUNTER=100 within 400 cycles");
    end
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== 25'd0) begin
        errors++;
        $display("FAIL abort_idle_after %0d: got %h expected %h", i, obs, 25'd0);
      end
      tick();
    end
    run_frame(0, 1'b0, n_done, done_cyc);
    checks++;
    if (n_done !== 1 || done_cyc !== 277 || pix_q.size() !== 4 || pix_q[3] !== 8'hCD) begin
      errors++;
      $display("FAIL abort_next_frame: got done %0d cycle %0d pixels %0d expected 1 277 4",
               n_done, done_cyc, pix_q.size());
    end
  endtask

  task automatic test_reset_mid_stream();
    int  n_done, done_cyc;
    bit  found;
    START = 1'b1;
    found = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      tick();
      START = 1'b0;
      if (OUT_VALID) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_reach: got no OUT_VALID expected OUT_VALID within 400 cycles");
    end
    #2;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL rst_async: got %h expected %h", obs, 25'd0);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    checks++;
    if (obs !== 25'd0) begin
      errors++;
      $display("FAIL rst_release: got %h expected %h", obs, 25'd0);
    end
    run_frame(0, 1'b0, n_done, done_cyc);
    checks++;
    if (n_done !== 1 || done_cyc !== 277 || pix_q.size() !== 4) begin
      errors++;
      $display("FAIL rst_next_frame: got done %0d cycle %0d pixels %0d expected 1 277 4",
               n_done, done_cyc, pix_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pix_q[i] !== exp_pix[i]) begin
          errors++;
          $display("FAIL rst_pixel %0d: got %h expected %h", i, pix_q[i], exp_pix[i]);
        end
      end
    end
  endtask

  initial begin
    RESET_N   = 1'b0;
    START     = 1'b0;
    ABORT     = 1'b0;
    OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    test_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    test_frame_timing();
    test_pixel_order();
    test_backpressure();
    test_start_ignored();
    test_abort();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_array_ctrl.md
PIXEL_ARRAY_CTRL -- requirements
Module: pixel_array_ctrl

Interface
REQ-001 SHALL have parameter PIXEL_ARRAY_HEIGHT, default 2, number of pixel rows.
REQ-002 SHALL have parameter PIXEL_ARRAY_WIDTH, default 2, number of pixel columns.
REQ-003 SHALL have parameter ERASE_CYCLES, default 4, ERASE pulse length in cycles (>=1).
REQ-004 SHALL have parameter EXPOSE_CYCLES, default 8, EXPOSE pulse length in cycles (>=1).
REQ-005 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port START  input  1  frame request, sampled in IDLE only.
REQ-008 SHALL have port ABORT  input  1  synchronous frame abort.
REQ-009 SHALL have port ERASE  output  1  array erase drive.
REQ-010 SHALL have port EXPOSE  output  1  array expose drive.
REQ-011 SHALL have port RAMP  output  1  ADC ramp enable.
REQ-012 SHALL have port COUNTER  output  8  ADC code broadcast to array.
REQ-013 SHALL have port READ  output  PIXEL_ARRAY_HEIGHT  one-hot row select.
REQ-014 SHALL have port DATA_IN  input  PIXEL_ARRAY_WIDTH x 8  column data from array.
REQ-015 SHALL have port OUT_DATA  output  8  streamed pixel value.
REQ-016 SHALL have port OUT_VALID  output  1  OUT_DATA valid.
REQ-017 SHALL have port OUT_READY  input  1  downstream accept.
REQ-018 SHALL have port OUT_LAST  output  1  high with final pixel of frame.
REQ-019 SHALL have port BUSY  output  1  high in any state except IDLE.
REQ-020 SHALL have port FRAME_DONE  output  1  one-cycle pulse at frame end.

Function
REQ-021 SHALL implement states IDLE, ERASE_S, EXPOSE_S, CONVERT, READ_ROW, STREAM.
REQ-022 IDLE: all outputs 0; START=1 -> ERASE_S next cycle; START ignored in every other state.
REQ-023 ERASE_S: ERASE=1 for exactly ERASE_CYCLES cycles, then EXPOSE_S.
REQ-024 EXPOSE_S: EXPOSE=1 for exactly EXPOSE_CYCLES cycles, then CONVERT.
REQ-025 CONVERT: RAMP=1 for 256 cycles, COUNTER=0,1,...,255 (one step per cycle, no wrap), then READ_ROW with row=0; COUNTER=0 outside CONVERT.
REQ-026 READ_ROW: READ=1<<row for exactly 2 cycles; DATA_IN captured into column buffer at the edge ending the second cycle; then STREAM with col=0.
REQ-027 READ SHALL be all-zero outside READ_ROW and never have more than one bit set.
REQ-028 STREAM: OUT_VALID=1, OUT_DATA=buffer[col]; col advances only on OUT_VALID&OUT_READY.
REQ-029 While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_LAST SHALL hold stable.
REQ-030 Pixel order: row 0 col 0 first, columns ascending, then rows ascending.
REQ-031 Acceptance of col=PIXEL_ARRAY_WIDTH-1: row<PIXEL_ARRAY_HEIGHT-1 -> row+1, READ_ROW; else IDLE with FRAME_DONE=1 for that next cycle.
REQ-032 OUT_LAST=1 only while presenting row=H-1, col=W-1.
REQ-033 ABORT=1 in any non-IDLE state -> IDLE next cycle, outputs 0, no FRAME_DONE, partial pixels discarded; ABORT in IDLE has no effect; ABORT wins over simultaneous START or handshake.
REQ-034 Row/column/phase counters SHALL be sized for the parameters; no overflow for H,W up to 256.

Reset
REQ-035 RESET_N=0 SHALL immediately force IDLE and zero ERASE, EXPOSE, RAMP, COUNTER, READ, OUT_DATA, OUT_VALID, OUT_LAST, BUSY, FRAME_DONE, and clear buffer and counters.
REQ-036 Reset asserted mid-frame SHALL discard the frame; first START after release begins a fresh frame.

Verification (H=2, W=2, defaults)
REQ-037 START pulse at cycle 0, OUT_READY=1 -> ERASE 1-4, EXPOSE 5-12, RAMP 13-268 with COUNTER 0..255, READ=01 269-270, pixels 271-272, READ=10 273-274, pixels 275-276, OUT_LAST at 276, FRAME_DONE at 277.
REQ-038 DATA_IN={row0:8'h12,8'h34; row1:8'hAB,8'hCD} (col0,col1) -> OUT_DATA sequence 12,34,AB,CD.
REQ-039 OUT_READY low 3 cycles on first pixel -> OUT_VALID held, OUT_DATA=12 stable, no pixel lost or duplicated.
REQ-040 START pulsed during EXPOSE_S and STREAM -> no effect; exactly one frame, one FRAME_DONE.
REQ-041 ABORT during CONVERT at COUNTER=100 -> next cycle IDLE, RAMP=0, COUNTER=0, no FRAME_DONE; following START runs full frame.
REQ-042 RESET_N low mid-STREAM -> all outputs 0 asynchronously, BUSY=0; new frame after release correct.
